bram_req_ctrl: RTL and testbench

- Initiator-side controller that drives the single-port synchronous `bram` block.
- Converts a valid/ready request stream (read or write, one word) into correctly timed BRAM port activity.
- Returns every request's result on a valid/ready response stream.
- Sits between the CPU/bus side and a `bram` instance; one transaction outstanding at a time.

---
 rtl/bram_req_ctrl.sv | 260 ++++++++++++++++++++++++++
 tb/tb_bram_req_ctrl.sv | 393 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_req_ctrl.sv
// -----------------------------------------------------------------------------
// bram_req_ctrl
//
// Initiator-side controller for a single-port synchronous BRAM. It accepts one
// read or write request at a time on a valid/ready request stream, drives the
// BRAM port with correctly timed registered signals, and returns the result on
// a valid/ready response stream.
//
// Handshake rule, both streams: a transfer happens at a rising edge of i_clk
// where valid and ready are both high. A valid source holds its payload
// stable until that edge. o_req_ready is high only in IDLE. o_rsp_valid is
// high only in RESP. o_rsp_valid, o_rsp_rdata and o_rsp_err stay stable until
// the response is taken.
//
// Optional feature macro: BRAM_CTRL_STRB_EN
//   When defined, i_req_strb selects the bytes a write updates:
//   - all ones gives a plain write;
//   - zero skips the BRAM;
//   - any other pattern is a read-modify-write through MERGE and WRBACK.
//   When undefined, i_req_strb is ignored and every write is a full word.
//
// Ports:
//   i_clk, i_rst_n      clock; asynchronous active-low reset
//   i_req_valid/o_req_ready, i_req_write, i_req_addr (word address),
//   i_req_wdata, i_req_strb                   request stream
//   o_rsp_valid/i_rsp_ready, o_rsp_rdata, o_rsp_err   response stream
//   o_mem_write, o_mem_addr, o_mem_wdata, i_mem_rdata  BRAM port (registered)
//   o_dbg_state         current FSM state, for observation only
//
// Cycle timing, with the request accepted at edge N:
//   error : RESP from edge N
//   write : ACCESS (o_mem_write=1), then RESP from edge N+1
//   read  : ACCESS, then CAPTURE, then RESP from edge N+2
//   RMW   : ACCESS, CAPTURE, MERGE, WRBACK (o_mem_write=1), then RESP from N+4
// -----------------------------------------------------------------------------
module bram_req_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_req_valid,
    output logic                    o_req_ready,
    input  logic                    i_req_write,
    input  logic [31:0]             i_req_addr,
    input  logic [DATA_WIDTH-1:0]   i_req_wdata,
    input  logic [DATA_WIDTH/8-1:0] i_req_strb,
    output logic                    o_rsp_valid,
    input  logic                    i_rsp_ready,
    output logic [DATA_WIDTH-1:0]   o_rsp_rdata,
    output logic                    o_rsp_err,
    output logic                    o_mem_write,
    output logic [ADDR_WIDTH-1:0]   o_mem_addr,
    output logic [DATA_WIDTH-1:0]   o_mem_wdata,
    input  logic [DATA_WIDTH-1:0]   i_mem_rdata,
    output logic [2:0]              o_dbg_state
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ACCESS  = 3'd1,
        CAPTURE = 3'd2,
        RESP    = 3'd3
`ifdef BRAM_CTRL_STRB_EN
        ,
        MERGE   = 3'd4,
        WRBACK  = 3'd5
`endif
    } state_t;

    state_t                  state_q, state_d;
    // Set when ACCESS must continue to CAPTURE. This covers reads and
    // read-modify-write.
    logic                    need_rdata_q, need_rdata_d;
    logic                    mem_write_q, mem_write_d;
    logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0]   mem_wdata_q, mem_wdata_d;
    logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                    rsp_err_q, rsp_err_d;
    logic                    addr_in_range;

`ifdef BRAM_CTRL_STRB_EN
    localparam int NB = DATA_WIDTH / 8;

    logic [NB-1:0]           strb_q, strb_d;
    logic                    rmw_q, rmw_d;

    // Replace the strobed bytes of old_word with the matching bytes of new_word.
    function automatic logic [DATA_WIDTH-1:0] merge_bytes(
        input logic [DATA_WIDTH-1:0] old_word,
        input logic [DATA_WIDTH-1:0] new_word,
        input logic [NB-1:0]         strb
    );
        logic [DATA_WIDTH-1:0] res;
        res = old_word;
        for (int b = 0; b < NB; b++) begin
            if (strb[b]) begin
                res[b*8 +: 8] = new_word[b*8 +: 8];
            end
        end
        return res;
    endfunction
`else
    // Strobes have no effect in this build.
    logic                    unused_strb;
    assign unused_strb = ^i_req_strb;
`endif

    // Addresses never wrap. Any nonzero bit above the BRAM range is an error.
    assign addr_in_range = (i_req_addr[31:ADDR_WIDTH] == '0);

    // ---------------------------------------------------------------------
    // Next-state and datapath logic
    // ---------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        need_rdata_d = need_rdata_q;
        mem_write_d  = 1'b0;            // the write strobe is a one-cycle pulse
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        rsp_rdata_d  = rsp_rdata_q;
        rsp_err_d    = rsp_err_q;
`ifdef BRAM_CTRL_STRB_EN
        strb_d       = strb_q;
        rmw_d        = rmw_q;
`endif

        case (state_q)
            IDLE: begin
                if (i_req_valid) begin
                    if (!addr_in_range) begin
                        rsp_err_d   = 1'b1;
                        rsp_rdata_d = '0;
                        state_d     = RESP;
                    end else begin
                        mem_addr_d  = i_req_addr[ADDR_WIDTH-1:0];
                        mem_wdata_d = i_req_wdata;
                        state_d     = ACCESS;
`ifdef BRAM_CTRL_STRB_EN
                        strb_d = i_req_strb;
                        if (!i_req_write) begin
                            need_rdata_d = 1'b1;
                            rmw_d        = 1'b0;
                        end else if (&i_req_strb) begin
                            mem_write_d  = 1'b1;
                            need_rdata_d = 1'b0;
                            rmw_d        = 1'b0;
                        end else if (i_req_strb == '0) begin
                            // Nothing to write. ACCESS is only a one-cycle
                            // pass-through to RESP.
                            need_rdata_d = 1'b0;
                            rmw_d        = 1'b0;
                        end else begin
                            // A partial write reads the word first.
                            need_rdata_d = 1'b1;
                            rmw_d        = 1'b1;
                        end
`else
                        mem_write_d  = i_req_write;
                        need_rdata_d = !i_req_write;
`endif
                    end
                end
            end

            ACCESS: begin
                state_d = need_rdata_q ? CAPTURE : RESP;
            end

            CAPTURE: begin
                // i_mem_rdata reflects the address sampled at the ACCESS edge.
`ifdef BRAM_CTRL_STRB_EN
                if (rmw_q) begin
                    mem_wdata_d = merge_bytes(i_mem_rdata, mem_wdata_q, strb_q);
                    state_d     = MERGE;
                end else begin
                    rsp_rdata_d = i_mem_rdata;
                    state_d     = RESP;
                end
`else
                rsp_rdata_d = i_mem_rdata;
                state_d     = RESP;
`endif
            end

`ifdef BRAM_CTRL_STRB_EN
            MERGE: begin
                // The merged word is already in mem_wdata_q. Raise the
                // strobe so it is visible during WRBACK.
                mem_write_d = 1'b1;
                state_d     = WRBACK;
            end

            WRBACK: begin
                state_d = RESP;
            end
`endif

            RESP: begin
                if (i_rsp_ready) begin
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b0;
                    state_d     = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // State registers
    // ---------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= IDLE;
            need_rdata_q <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            rsp_rdata_q  <= '0;
            rsp_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            need_rdata_q <= need_rdata_d;
            mem_write_q  <= mem_write_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            rsp_rdata_q  <= rsp_rdata_d;
            rsp_err_q    <= rsp_err_d;
        end
    end

`ifdef BRAM_CTRL_STRB_EN
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            strb_q <= '0;
            rmw_q  <= 1'b0;
        end else begin
            strb_q <= strb_d;
            rmw_q  <= rmw_d;
        end
    end
`endif

    // ---------------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------------
    assign o_req_ready = (state_q == IDLE);
    assign o_rsp_valid = (state_q == RESP);
    assign o_rsp_rdata = rsp_rdata_q;
    assign o_rsp_err   = rsp_err_q;
    assign o_mem_write = mem_write_q;
    assign o_mem_addr  = mem_addr_q;
    assign o_mem_wdata = mem_wdata_q;
    assign o_dbg_state = state_q;

endmodule

// File: tb/tb_bram_req_ctrl.sv
// -----------------------------------------------------------------------------
// tb_bram_req_ctrl
//
// Testbench for bram_req_ctrl. It contains a simple BRAM with one-cycle read
// latency, a reference model of the controller, and one compare process that
// checks every DUT output on every falling edge.
//
// The reference model keeps its own copy of memory. For each transaction it
// records the expected latency, the cycle at which o_mem_write should pulse,
// and the expected response.
//
// Set BRAM_CTRL_STRB_EN to exercise the byte-strobe path.
// -----------------------------------------------------------------------------
module tb_bram_req_ctrl;

    localparam int DW = 32;
    localparam int AW = 10;
    localparam int NB = DW / 8;
    localparam int DEPTH = 1 << AW;

    // ---------------------------------------------------------------------
    // Clock, reset, DUT
    // ---------------------------------------------------------------------
    logic          i_clk;
    logic          i_rst_n;
    logic          i_req_valid;
    logic          o_req_ready;
    logic          i_req_write;
    logic [31:0]   i_req_addr;
    logic [DW-1:0] i_req_wdata;
    logic [NB-1:0] i_req_strb;
    logic          o_rsp_valid;
    logic          i_rsp_ready = 1'b1;
    logic [DW-1:0] o_rsp_rdata;
    logic          o_rsp_err;
    logic          o_mem_write;
    logic [AW-1:0] o_mem_addr;
    logic [DW-1:0] o_mem_wdata;
    logic [DW-1:0] i_mem_rdata;
    logic [2:0]    unused_dbg_state;

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    bram_req_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_req_valid (i_req_valid),
        .o_req_ready (o_req_ready),
        .i_req_write (i_req_write),
        .i_req_addr  (i_req_addr),
        .i_req_wdata (i_req_wdata),
        .i_req_strb  (i_req_strb),
        .o_rsp_valid (o_rsp_valid),
        .i_rsp_ready (i_rsp_ready),
        .o_rsp_rdata (o_rsp_rdata),
        .o_rsp_err   (o_rsp_err),
        .o_mem_write (o_mem_write),
        .o_mem_addr  (o_mem_addr),
        .o_mem_wdata (o_mem_wdata),
        .i_mem_rdata (i_mem_rdata),
        .o_dbg_state (unused_dbg_state)
    );

    // ---------------------------------------------------------------------
    // BRAM, with a preload port that lets the bench seed its contents
    // ---------------------------------------------------------------------
    logic [DW-1:0] bram_mem [0:DEPTH-1];
    logic [DW-1:0] bram_q;
    logic          pre_we = 1'b0;
    logic [AW-1:0] pre_addr;
    logic [DW-1:0] pre_data;

    always @(posedge i_clk) begin
        if (pre_we) bram_mem[pre_addr] <= pre_data;
        else if (o_mem_write) bram_mem[o_mem_addr] <= o_mem_wdata;
        bram_q <= bram_mem[o_mem_addr];
    end
    assign i_mem_rdata = bram_q;

    int cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    // Response-ready policy. 0 = always ready, 1 = random, 2 = held low.
    int rsp_mode = 0;
    always @(posedge i_clk) begin
        #2;
        case (rsp_mode)
            0:       i_rsp_ready = 1'b1;
            1:       i_rsp_ready = ($urandom_range(0, 3) != 0);
            default: i_rsp_ready = 1'b0;
        endcase
    end

    // ---------------------------------------------------------------------
    // Scoreboard bookkeeping
    // ---------------------------------------------------------------------
    int n_vec  = 0;
    int n_miss = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic note_fail(input string nm);
        n_vec++;
        n_miss++;
        $display("FAIL %s: bound expired (t=%0t)", nm, $time);
    endtask

    function automatic logic [DW-1:0] apply_strb(input logic [DW-1:0] old_w,
                                                 input logic [DW-1:0] new_w,
                                                 input logic [NB-1:0] s);
        logic [DW-1:0] r;
        r = old_w;
        for (int b = 0; b < NB; b++) if (s[b]) r[b*8 +: 8] = new_w[b*8 +: 8];
        return r;
    endfunction

    // ---------------------------------------------------------------------
    // Reference model state
    // ---------------------------------------------------------------------
    logic [DW-1:0] ref_mem [0:DEPTH-1];
    logic [DW:0]   exp_q[$];          // {err, rdata} of the outstanding response
    logic [DW:0]   last_rsp;          // last response the model retired
    logic          busy = 1'b0;
    int            acc_cyc = 0;       // value of cyc right after the accept edge
    int            cur_lat = 0;       // cycles from the accept edge to the first valid cycle
    int            cur_mw_k = -1;     // cycle offset where o_mem_write must be high
    logic          cur_rd = 1'b0;     // the transaction issues a BRAM read
    logic [AW-1:0] cur_addr = '0;
    logic [DW-1:0] cur_word = '0;
    int            acc_count = 0;
    int            n_rsp = 0;

    // ---------------------------------------------------------------------
    // Compare process. On each falling edge it checks every output, then
    // predicts what the next rising edge will do.
    // ---------------------------------------------------------------------
    always @(negedge i_clk) begin
        int          k;
        logic        exp_valid;
        logic        exp_mw;
        logic [DW:0] head;
        if (!i_rst_n) begin
            busy = 1'b0;
            exp_q.delete();
        end else begin
            if (pre_we) ref_mem[pre_addr] = pre_data;
            k         = cyc - acc_cyc;
            exp_valid = busy && (k >= cur_lat);
            exp_mw    = busy && (k == cur_mw_k);
            head      = (exp_q.size() > 0) ? exp_q[0] : '0;

            chk("req_ready", 64'(o_req_ready), 64'(!busy));
            chk("rsp_valid", 64'(o_rsp_valid), 64'(exp_valid));
            chk("rsp_rdata", 64'(o_rsp_rdata), exp_valid ? 64'(head[DW-1:0]) : 64'd0);
            chk("rsp_err",   64'(o_rsp_err),   exp_valid ? 64'(head[DW])     : 64'd0);
            chk("mem_write", 64'(o_mem_write), 64'(exp_mw));
            if (exp_mw) begin
                chk("mem_addr",  64'(o_mem_addr),  64'(cur_addr));
                chk("mem_wdata", 64'(o_mem_wdata), 64'(cur_word));
            end
            if (busy && k == 0 && cur_rd) chk("rd_addr", 64'(o_mem_addr), 64'(cur_addr));

            if (busy && exp_valid && i_rsp_ready) begin
                last_rsp = exp_q.pop_front();
                busy     = 1'b0;
                n_rsp++;
            end else if (!busy && i_req_valid) begin
                cur_addr = i_req_addr[AW-1:0];
                cur_mw_k = -1;
                cur_rd   = 1'b0;
                cur_word = '0;
                if (i_req_addr >= 32'(DEPTH)) begin
                    cur_lat = 0;
                    exp_q.push_back({1'b1, {DW{1'b0}}});
                end else if (!i_req_write) begin
                    cur_lat = 2;
                    cur_rd  = 1'b1;
                    exp_q.push_back({1'b0, ref_mem[cur_addr]});
                end else begin
`ifdef BRAM_CTRL_STRB_EN
                    if (i_req_strb == '1) begin
                        cur_lat = 1; cur_mw_k = 0; cur_word = i_req_wdata;
                        ref_mem[cur_addr] = i_req_wdata;
                    end else if (i_req_strb == '0) begin
                        cur_lat = 1;
                    end else begin
                        cur_lat = 4; cur_mw_k = 3; cur_rd = 1'b1;
                        cur_word = apply_strb(ref_mem[cur_addr], i_req_wdata, i_req_strb);
                        ref_mem[cur_addr] = cur_word;
                    end
`else
                    cur_lat = 1; cur_mw_k = 0; cur_word = i_req_wdata;
                    ref_mem[cur_addr] = i_req_wdata;
`endif
                    exp_q.push_back({1'b0, {DW{1'b0}}});
                end
                acc_cyc = cyc + 1;
                busy    = 1'b1;
                acc_count++;
            end
        end
    end

    // ---------------------------------------------------------------------
    // Driver tasks. Each one is entered 1 time unit after a rising edge.
    // ---------------------------------------------------------------------
    task automatic send(input logic w, input logic [31:0] a, input logic [DW-1:0] d,
                        input logic [NB-1:0] s);
        int prev;
        prev        = acc_count;
        i_req_valid = 1'b1;
        i_req_write = w;
        i_req_addr  = a;
        i_req_wdata = d;
        i_req_strb  = s;
        for (int t = 0; t < 200 && acc_count == prev; t++) begin
            @(posedge i_clk);
            #1;
        end
        if (acc_count == prev) note_fail("send_accept");
        // Once the request is accepted, the request fields are ignored.
        // Drive random values to show that.
        i_req_valid = 1'b0;
        i_req_write = 1'($urandom_range(0, 1));
        i_req_addr  = $urandom();
        i_req_wdata = $urandom();
        i_req_strb  = NB'($urandom());
    endtask

    task automatic wait_done();
        for (int t = 0; t < 500 && busy; t++) begin
            @(posedge i_clk);
            #1;
        end
        if (busy) note_fail("wait_response");
    endtask

    task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
        pre_we   = 1'b1;
        pre_addr = a;
        pre_data = d;
        @(posedge i_clk);
        #1;
        pre_we = 1'b0;
    endtask

    // ---------------------------------------------------------------------
    // Stimulus
    // ---------------------------------------------------------------------
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        i_rst_n     = 1'b0;
        i_req_valid = 1'b0;
        i_req_write = 1'b0;
        i_req_addr  = '0;
        i_req_wdata = '0;
        i_req_strb  = '0;
        repeat (3) @(posedge i_clk);
        #1;
        chk("rst_req_ready", 64'(o_req_ready), 64'd1);
        chk("rst_rsp_valid", 64'(o_rsp_valid), 64'd0);
        chk("rst_rsp_err",   64'(o_rsp_err),   64'd0);
        chk("rst_rsp_rdata", 64'(o_rsp_rdata), 64'd0);
        chk("rst_mem_write", 64'(o_mem_write), 64'd0);
        chk("rst_mem_addr",  64'(o_mem_addr),  64'd0);
        chk("rst_mem_wdata", 64'(o_mem_wdata), 64'd0);
        i_rst_n = 1'b1;
        @(posedge i_clk);
        #1;

        // Fill the BRAM, and the model's copy, with random contents.
        for (int i = 0; i < DEPTH; i++) preload(AW'(i), $urandom());

        // Write 'hAA to address 0, then read it back.
        send(1'b1, 32'd0, 32'hAA, '1);
        wait_done();
        chk("t1_wr_err",   64'(last_rsp[DW]),     64'd0);
        chk("t1_wr_rdata", 64'(last_rsp[DW-1:0]), 64'd0);
        send(1'b0, 32'd0, 32'd0, '0);
        wait_done();
        chk("t1_rd_rdata", 64'(last_rsp[DW-1:0]), 64'hAA);

        // An out-of-range write errors. Address 0 keeps its old contents.
        send(1'b1, 32'h400, 32'h55, '1);
        wait_done();
        chk("oor_err",   64'(last_rsp[DW]),     64'd1);
        chk("oor_rdata", 64'(last_rsp[DW-1:0]), 64'd0);
        send(1'b0, 32'd0, 32'd0, '0);
        wait_done();
        chk("oor_rd0", 64'(last_rsp[DW-1:0]), 64'hAA);

        // Write i+1 to address 2i+1 back to back, then read everything back.
        for (int i = 0; i < 32; i++) send(1'b1, 32'(2*i + 1), 32'(i + 1), '1);
        wait_done();
        for (int i = 0; i < 32; i++) begin
            send(1'b0, 32'(2*i + 1), 32'd0, '0);
            wait_done();
            chk("seq_rd", 64'(last_rsp[DW-1:0]), 64'(i + 1));
        end

        // Hold the consumer off for 10 response cycles.
        preload(AW'(5), 32'hAABBCCDD);
        n0       = n_rsp;
        rsp_mode = 2;
        send(1'b0, 32'd5, 32'd0, '0);
        repeat (12) begin
            @(posedge i_clk);
            #1;
        end
        rsp_mode = 0;
        wait_done();
        chk("stall_rdata", 64'(last_rsp[DW-1:0]), 64'hAABBCCDD);
        chk("stall_count", 64'(n_rsp), 64'(n0 + 1));

        // Reset while a write is in ACCESS. The write data matches the
        // stored word, so the outcome is the same whether it lands or not.
        preload(AW'(7), 32'h12345678);
        send(1'b1, 32'd7, 32'h12345678, '1);
        chk("rst_mid_in_access", 64'(o_mem_write), 64'd1);
        i_rst_n = 1'b0;
        #1;
        chk("rst_mid_req_ready", 64'(o_req_ready), 64'd1);
        chk("rst_mid_rsp_valid", 64'(o_rsp_valid), 64'd0);
        chk("rst_mid_mem_write", 64'(o_mem_write), 64'd0);
        chk("rst_mid_mem_addr",  64'(o_mem_addr),  64'd0);
        chk("rst_mid_mem_wdata", 64'(o_mem_wdata), 64'd0);
        repeat (2) @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
        @(posedge i_clk);
        #1;
        chk("rst_rel_req_ready", 64'(o_req_ready), 64'd1);
        send(1'b0, 32'd7, 32'd0, '0);
        wait_done();
        chk("rst_rel_rd7", 64'(last_rsp[DW-1:0]), 64'h12345678);

`ifdef BRAM_CTRL_STRB_EN
        // A partial-strobe write merges bytes. A zero-strobe write changes nothing.
        preload(AW'(3), 32'h11223344);
        send(1'b1, 32'd3, 32'hAABBCCDD, 4'b0101);
        wait_done();
        send(1'b0, 32'd3, 32'd0, '0);
        wait_done();
        chk("rmw_rd3", 64'(last_rsp[DW-1:0]), 64'h11BB33DD);
        send(1'b1, 32'd3, 32'hFFFFFFFF, 4'b0000);
        wait_done();
        send(1'b0, 32'd3, 32'd0, '0);
        wait_done();
        chk("zstrb_rd3", 64'(last_rsp[DW-1:0]), 64'h11BB33DD);
`endif

        // Random traffic with random response back-pressure.
        rsp_mode = 1;
        for (int i = 0; i < 400; i++) begin
            logic [31:0]   a;
            logic [NB-1:0] s;
            a = ($urandom_range(0, 7) == 0) ? $urandom() : 32'($urandom_range(0, DEPTH - 1));
            case ($urandom_range(0, 3))
                0:       s = '0;
                1, 2:    s = '1;
                default: s = NB'($urandom());
            endcase
            send(1'($urandom_range(0, 1)), a, $urandom(), s);
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) begin
                    @(posedge i_clk);
                    #1;
                end
            end
        end
        wait_done();
        rsp_mode = 0;
        repeat (2) @(posedge i_clk);
        #1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
